// File: rtl/bias_seq_pkg.sv
// Shared types and constants for the opamp bias enable sequencer.
package bias_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BREAK = 2'b01,
        MAKE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_L   = 2'b01;
    localparam logic [1:0] MODE_H   = 2'b10;
    localparam logic [1:0] MODE_LH  = 2'b11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/bias_seq_timer.sv
// Loadable down-counter for the discharge and settle windows; done while the count is zero.
module bias_seq_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear wins over load, and the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/bias_seq_ctrl.sv
// Break-before-make sequencer driving EN_RESL/EN_RESH of the root-current generator,
// with timed discharge and settle windows and a bias-valid report.
module bias_seq_ctrl
    import bias_seq_pkg::*;
#(
    parameter int OFF_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 256,
    parameter int CNT_W = $clog2((OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    output logic       en_resl,
    output logic       en_resh,
    output logic       bias_ok,
    output logic [1:0] cur_mode,
    output logic [1:0] state,
    output logic [7:0] xfer_cnt
);

    localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_r;
    logic [1:0]       cur_mode_r;
    logic [1:0]       target_r;
    logic [1:0]       en_r;
    logic             bias_ok_r;
    logic [7:0]       xfer_cnt_r;
    logic             accept_s;
    logic             change_s;
    logic             tmr_clear_s;
    logic             tmr_load_s;
    logic             tmr_done_s;
    logic [CNT_W-1:0] tmr_val_s;

    assign req_ready   = ena && (state_r == IDLE);
    assign accept_s    = req_valid && req_ready;
    assign change_s    = accept_s && (req_mode != cur_mode_r);
    assign tmr_clear_s = ~ena;

    // Timer load select: discharge window unless starting from off, settle window after BREAK.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_r)
            IDLE: begin
                if (change_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = (cur_mode_r == MODE_OFF) ? SETTLE_LOAD : OFF_LOAD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            BREAK: begin
                if (tmr_done_s && (target_r != MODE_OFF)) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETTLE_LOAD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    bias_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear_s),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .done     (tmr_done_s)
    );

    // Sequencer state and registered outputs; ena low overrides expiry and acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cur_mode_r <= MODE_OFF;
            target_r   <= MODE_OFF;
            en_r       <= MODE_OFF;
            bias_ok_r  <= 1'b0;
            xfer_cnt_r <= 8'd0;
        end else if (!ena) begin
            state_r    <= IDLE;
            cur_mode_r <= MODE_OFF;
            target_r   <= MODE_OFF;
            en_r       <= MODE_OFF;
            bias_ok_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (change_s) begin
                        target_r  <= req_mode;
                        bias_ok_r <= 1'b0;
                        // Enables are already low when off, so the discharge window is skipped.
                        if (cur_mode_r == MODE_OFF) begin
                            state_r <= MAKE;
                            en_r    <= req_mode;
                        end else begin
                            state_r <= BREAK;
                            en_r    <= MODE_OFF;
                        end
                    end
                end
                BREAK: begin
                    if (tmr_done_s) begin
                        if (target_r == MODE_OFF) begin
                            state_r    <= IDLE;
                            cur_mode_r <= MODE_OFF;
                            xfer_cnt_r <= sat_inc8(xfer_cnt_r);
                        end else begin
                            state_r <= MAKE;
                            en_r    <= target_r;
                        end
                    end
                end
                MAKE: begin
                    if (tmr_done_s) begin
                        state_r    <= IDLE;
                        cur_mode_r <= target_r;
                        bias_ok_r  <= (target_r != MODE_OFF);
                        xfer_cnt_r <= sat_inc8(xfer_cnt_r);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cur_mode_r <= MODE_OFF;
                    en_r       <= MODE_OFF;
                    bias_ok_r  <= 1'b0;
                end
            endcase
        end
    end

    assign en_resl  = en_r[0];
    assign en_resh  = en_r[1];
    assign bias_ok  = bias_ok_r;
    assign cur_mode = cur_mode_r;
    assign state    = state_r;
    assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Scoreboard bench for bias_seq_ctrl: stimulus queues expected accept/completion records,
// a negedge monitor pops them when the DUT accepts a request or returns to IDLE.
module tb_bias_seq_ctrl;
    import bias_seq_pkg::*;

    localparam int OFF = 16;
    localparam int SET = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic       en_resl;
    logic       en_resh;
    logic       bias_ok;
    logic [1:0] cur_mode;
    logic [1:0] state;
    logic [7:0] xfer_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int viol        = 0;

    typedef struct {
        logic [1:0] st;
        logic [1:0] en;
        bit         after_done;
    } acc_t;

    typedef struct {
        int         lat;
        logic [1:0] mode;
        logic       bias;
        logic [7:0] cnt;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];
    acc_t  ma;
    done_t md;
    logic [7:0] exp_cnt = 8'd0;

    bias_seq_ctrl #(
        .OFF_CYCLES    (OFF),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .en_resl   (en_resl),
        .en_resh   (en_resh),
        .bias_ok   (bias_ok),
        .cur_mode  (cur_mode),
        .state     (state),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_acc(input logic [1:0] st, input logic [1:0] en, input bit ad);
        acc_t a;
        a.st = st;
        a.en = en;
        a.after_done = ad;
        acc_q.push_back(a);
    endtask

    task automatic expect_done(input int lat, input logic [1:0] mode);
        done_t d;
        exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
        d.lat  = lat;
        d.mode = mode;
        d.bias = (mode != MODE_OFF);
        d.cnt  = exp_cnt;
        done_q.push_back(d);
    endtask

    task automatic drive_req(input logic [1:0] m);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = m;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: req_ready stayed 0 for mode %0d", m);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    logic [1:0] prev_state = 2'b00;
    logic       prev_ena   = 1'b0;
    logic       prev_rst   = 1'b1;
    bit         acc_pend   = 1'b0;
    int         acc_edge   = 0;
    int         last_done_edge = -10;
    logic [1:0] last_nz    = 2'b00;
    int         zero_run   = 0;

    // Monitor: pop and compare on acceptance and on normal completion; track enable invariants.
    always @(negedge clk) begin
        #1;
        if (acc_pend) begin
            acc_pend = 1'b0;
            if (acc_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_accept: mode %0d accepted at edge %0d, none expected", req_mode, acc_edge);
            end else begin
                ma = acc_q.pop_front();
                check("acc_state", state, ma.st);
                check("acc_enables", {en_resh, en_resl}, ma.en);
                if (ma.after_done) check("acc_first_idle", acc_edge - last_done_edge, 1);
            end
        end
        if (prev_state != 2'b00 && state == 2'b00 && prev_ena && !prev_rst) begin
            last_done_edge = cyc;
            if (done_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: completion at edge %0d, none expected", cyc);
            end else begin
                md = done_q.pop_front();
                check("done_latency", cyc - acc_edge, md.lat);
                check("done_cur_mode", cur_mode, md.mode);
                check("done_bias_ok", bias_ok, md.bias);
                check("done_xfer_cnt", xfer_cnt, md.cnt);
                check("done_enables", {en_resh, en_resl}, md.mode);
            end
        end
        if (state != 2'b00 && bias_ok) viol++;
        if (state == 2'b00 && {en_resh, en_resl} != cur_mode) viol++;
        if ({en_resh, en_resl} == 2'b00) begin
            zero_run++;
        end else begin
            if (last_nz != 2'b00 && {en_resh, en_resl} != last_nz && zero_run < OFF) viol++;
            zero_run = 0;
            last_nz  = {en_resh, en_resl};
        end
        if (!ena || rst) last_nz = 2'b00;
        if (req_valid && req_ready && !rst) begin
            acc_pend = 1'b1;
            acc_edge = cyc + 1;
        end
        prev_state = state;
        prev_ena   = ena;
        prev_rst   = rst;
    end

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        req_valid = 1'b0;
        req_mode  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 2'b00);
        check("rst_enables", {en_resh, en_resl}, 2'b00);
        check("rst_bias_ok", bias_ok, 1'b0);
        check("rst_cur_mode", cur_mode, 2'b00);
        check("rst_xfer_cnt", xfer_cnt, 8'd0);
        check("ready_ena_low", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;
        #2 check("ready_follows_ena", req_ready, 1'b1);

        // Off -> L directly through MAKE.
        expect_acc(MAKE, MODE_L, 1'b0);
        expect_done(SET, MODE_L);
        drive_req(MODE_L);
        // L -> H via BREAK.
        expect_acc(BREAK, MODE_OFF, 1'b0);
        expect_done(OFF + SET, MODE_H);
        drive_req(MODE_H);
        // Same-mode request is a no-op.
        expect_acc(IDLE, MODE_H, 1'b0);
        drive_req(MODE_H);
        repeat (3) @(negedge clk);
        check("noop_xfer_cnt", xfer_cnt, exp_cnt);
        check("noop_state", state, 2'b00);
        // H -> LH, then LH -> off.
        expect_acc(BREAK, MODE_OFF, 1'b0);
        expect_done(OFF + SET, MODE_LH);
        drive_req(MODE_LH);
        expect_acc(BREAK, MODE_OFF, 1'b0);
        expect_done(OFF, MODE_OFF);
        drive_req(MODE_OFF);
        // Request held through MAKE is taken on the first IDLE cycle.
        expect_acc(MAKE, MODE_L, 1'b0);
        expect_done(SET, MODE_L);
        drive_req(MODE_L);
        expect_acc(BREAK, MODE_OFF, 1'b1);
        expect_done(OFF + SET, MODE_H);
        drive_req(MODE_H);

        // ena drop mid-MAKE.
        expect_acc(BREAK, MODE_OFF, 1'b0);
        expect_done(OFF, MODE_OFF);
        drive_req(MODE_OFF);
        expect_acc(MAKE, MODE_L, 1'b0);
        drive_req(MODE_L);
        repeat (100) @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("ena_drop_state", state, 2'b00);
        check("ena_drop_enables", {en_resh, en_resl}, 2'b00);
        check("ena_drop_bias_ok", bias_ok, 1'b0);
        check("ena_drop_cur_mode", cur_mode, 2'b00);
        check("ena_drop_xfer_cnt", xfer_cnt, exp_cnt);
        @(negedge clk);
        req_valid = 1'b1;
        req_mode  = MODE_H;
        repeat (20) @(negedge clk);
        check("ena_low_ready", req_ready, 1'b0);
        check("ena_low_enables", {en_resh, en_resl}, 2'b00);
        req_valid = 1'b0;
        ena = 1'b1;

        // Reset asserted mid-BREAK.
        expect_acc(MAKE, MODE_L, 1'b0);
        expect_done(SET, MODE_L);
        drive_req(MODE_L);
        expect_acc(BREAK, MODE_OFF, 1'b0);
        drive_req(MODE_H);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midbreak_rst_state", state, 2'b00);
        check("midbreak_rst_enables", {en_resh, en_resl}, 2'b00);
        check("midbreak_rst_bias_ok", bias_ok, 1'b0);
        check("midbreak_rst_cur_mode", cur_mode, 2'b00);
        check("midbreak_rst_xfer_cnt", xfer_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;

        // Saturation: 260 completed transitions toggling L / off.
        for (int i = 0; i < 130; i++) begin
            expect_acc(MAKE, MODE_L, 1'b0);
            expect_done(SET, MODE_L);
            drive_req(MODE_L);
            expect_acc(BREAK, MODE_OFF, 1'b0);
            expect_done(OFF, MODE_OFF);
            drive_req(MODE_OFF);
        end
        for (int i = 0; i < 2000 && done_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("sat_xfer_cnt", xfer_cnt, 8'd255);
        check("queues_drained", acc_q.size() + done_q.size(), 0);
        check("enable_invariant_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
